// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg -- shared definitions for the logic_unit_pipe block.
//   OP_W  : width of the operation select field
//   op_e  : operation encoding (bitwise ops across the operand width)
package logic_unit_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_PASS = 3'd7
  } op_e;

endpackage

// File: rtl/logic_unit_stage.sv
// logic_unit_stage -- one valid/ready pipeline register slice.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : upstream handshake; in_ready = !valid || out_ready
//   in_data             : payload captured on an upstream handshake
//   out_valid/out_ready : downstream handshake
//   out_data            : registered payload, held while stalled
module logic_unit_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid;
  logic [W-1:0] data;

  // Slice can take new data when empty or when its content leaves this cycle.
  assign in_ready  = !valid || out_ready;
  assign out_valid = valid;
  assign out_data  = data;

  // Payload/valid register: load on accept, empty on drain, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= {W{1'b0}};
    end else if (in_valid && in_ready) begin
      valid <= 1'b1;
      data  <= in_data;
    end else if (out_ready) begin
      valid <= 1'b0;
    end else begin
      valid <= valid;
      data  <= data;
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe -- two-stage valid/ready pipelined bitwise logic unit.
// Stage 1 registers {op, b, a}; stage 2 registers the computed result.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : input handshake
//   a, b, op            : operands and operation select (logic_unit_pkg::op_e)
//   out_valid/out_ready : output handshake
//   result              : bitwise result
//   out_red             : {xor, or, and} reduction flags of result
//   txn_count           : completed output handshakes, wraps at 2^CNT_W
// Build option: define LOGIC_UNIT_PIPE_REDUCE_EN to register the reduction
// flags alongside the result; otherwise out_red is constant 3'b000.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       out_red,
  output logic [CNT_W-1:0] txn_count
);

  localparam int S1_W = OP_W + 2 * WIDTH;
`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
  localparam int S2_W = WIDTH + 3;
`else
  localparam int S2_W = WIDTH;
`endif

  logic             s1_valid;
  logic             s2_ready;
  logic [S1_W-1:0]  s1_data;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_e              s1_op;
  logic [WIDTH-1:0] res_next;
  logic [S2_W-1:0]  s2_in;
  logic [S2_W-1:0]  s2_data;

`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
  // {xor, or, and} reduction of a result word.
  function automatic logic [2:0] reduce_flags(input logic [WIDTH-1:0] v);
    reduce_flags = {^v, |v, &v};
  endfunction
`endif

  logic_unit_stage #(.W(S1_W)) u_stage1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({op, b, a}),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_data)
  );

  assign s1_a  = s1_data[WIDTH-1:0];
  assign s1_b  = s1_data[2*WIDTH-1:WIDTH];
  assign s1_op = op_e'(s1_data[S1_W-1:2*WIDTH]);

  // Bitwise operation on the stage-1 operands; b unused for NOT/PASS.
  always_comb begin
    res_next = {WIDTH{1'b0}};
    case (s1_op)
      OP_AND:  res_next = s1_a & s1_b;
      OP_OR:   res_next = s1_a | s1_b;
      OP_XOR:  res_next = s1_a ^ s1_b;
      OP_NAND: res_next = ~(s1_a & s1_b);
      OP_NOR:  res_next = ~(s1_a | s1_b);
      OP_XNOR: res_next = ~(s1_a ^ s1_b);
      OP_NOT:  res_next = ~s1_a;
      OP_PASS: res_next = s1_a;
      default: res_next = {WIDTH{1'b0}};
    endcase
  end

  // Flags are computed from the value being loaded, so the registered copy
  // always matches the registered result.
`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
  assign s2_in = {reduce_flags(res_next), res_next};
`else
  assign s2_in = res_next;
`endif

  logic_unit_stage #(.W(S2_W)) u_stage2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (s2_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_data)
  );

  assign result = s2_data[WIDTH-1:0];
`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
  assign out_red = s2_data[S2_W-1:WIDTH];
`else
  assign out_red = 3'b000;
`endif

  // Completed output handshakes, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_count <= {CNT_W{1'b0}};
    end else if (out_valid && out_ready) begin
      txn_count <= txn_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      txn_count <= txn_count;
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic [2:0] op = 3'd0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] result;
  logic [2:0] out_red;
  logic [3:0] txn_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [10:0] q[$];  // expected {out_red, result}

  logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_red   (out_red),
    .txn_count (txn_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Expected reduction flags given the hand-computed {xor,or,and} value.
  function automatic logic [2:0] exp_red(input logic [2:0] red_on);
`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
    return red_on;
`else
    return 3'b000;
`endif
  endfunction

  function automatic logic [7:0] model_res(input logic [7:0] x, input logic [7:0] y, input logic [2:0] o);
    case (o)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x ^ y;
      3'd3: return ~(x & y);
      3'd4: return ~(x | y);
      3'd5: return ~(x ^ y);
      3'd6: return ~x;
      default: return x;
    endcase
  endfunction

  function automatic logic [2:0] model_red(input logic [7:0] r);
    return exp_red({^r, |r, &r});
  endfunction

  // Present one input and wait (bounded) for acceptance; push expectation.
  task automatic send(input logic [7:0] ta, input logic [7:0] tb_, input logic [2:0] top,
                      input logic [7:0] eres, input logic [2:0] ered);
    bit done = 1'b0;
    a = ta; b = tb_; op = top; in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back({ered, eres});
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout got=stalled exp=accepted");
    end
  endtask

  task automatic send_m(input logic [7:0] ta, input logic [7:0] tb_, input logic [2:0] top);
    logic [7:0] r;
    r = model_res(ta, tb_, top);
    send(ta, tb_, top, r, model_red(r));
  endtask

  // Wait (bounded) until every expected result has been consumed.
  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    check("drain_empty", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: any presented output must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output got=%0h exp=none", result);
      end else begin
        check("result", result, q[0][7:0]);
        check("out_red", out_red, q[0][10:8]);
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] tab_res [8] = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'h0F, 8'hF0};
  int t0;

  initial begin
    // Reset state
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_txn", txn_count, 0);
    check("rst_result", result, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All ops on F0/3C, latency 2 on the first one
    out_ready = 1'b1;
    send(8'hF0, 8'h3C, 3'd0, tab_res[0], exp_red(3'b010));
    check("lat_edge1_valid", out_valid, 0);
    @(posedge clk);
    #1;
    check("lat_edge2_valid", out_valid, 1);
    for (int i = 1; i < 8; i++) send(8'hF0, 8'h3C, 3'(i), tab_res[i], exp_red(3'b010));
    drain();
    check("txn_after_ops", txn_count, 8);

    // Backpressure: two accepts fill the pipe, third waits
    out_ready = 1'b0;
    send_m(8'h5A, 8'h0F, 3'd2);
    send_m(8'hA5, 8'h3C, 3'd1);
    a = 8'h81; b = 8'h7E; op = 3'd4; in_valid = 1'b1;
    #1;
    check("full_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    check("full_in_ready_hold", in_ready, 0);
    check("full_out_valid", out_valid, 1);
    out_ready = 1'b1;
    send_m(8'h81, 8'h7E, 3'd4);
    drain();
    check("txn_after_bp", txn_count, 11);

    // Reset with both stages full
    out_ready = 1'b0;
    send_m(8'h12, 8'h34, 3'd0);
    send_m(8'h56, 8'h78, 3'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_txn", txn_count, 0);
    check("midrst_result", result, 0);
    check("midrst_out_red", out_red, 0);
    check("midrst_in_ready", in_ready, 1);
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("post_rst_no_stale", out_valid, 0);
    end

    // 20 back-to-back transactions, counter wraps at 16
    t0 = cyc;
    for (int i = 0; i < 20; i++) send_m(8'(i * 37 + 5), 8'(i * 91 + 3), 3'(i % 8));
    check("stream_cycles", cyc - t0, 20);
    drain();
    check("txn_wrap", txn_count, 4);

    // Reduction flags
    send(8'hFF, 8'h00, 3'd7, 8'hFF, exp_red(3'b011));
    send(8'h01, 8'h00, 3'd7, 8'h01, exp_red(3'b110));
    send(8'h00, 8'h00, 3'd7, 8'h00, exp_red(3'b000));
    drain();
    check("txn_final", txn_count, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
